muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide execution unit. Consumes the two source operands
//  read from the register file (out1/out2), computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU,
//  and drives the register-file write port (RD, Data_in, enW) on completion.
//  Sits between register read and writeback. The core stalls while busy is high.
// PARAMETERS
//  XLEN   32  operand/result width; sequencing counter runs XLEN iterations
//  RD_W   5   destination register index width
// PORTS
//  clk      in   1     clock, all state updates on rising edge
//  reset    in   1     asynchronous, active-low reset
//  start    in   1     request pulse; operands/funct3/rd_in sampled on accepting edge
//  funct3   in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1_val  in   XLEN  operand A (dividend / multiplicand), from register file out1
//  rs2_val  in   XLEN  operand B (divisor / multiplier), from register file out2
//  rd_in    in   RD_W  destination register index
//  busy     out  1     high while iterating (states MUL, DIV)
//  done     out  1     one-cycle completion pulse
//  result   out  XLEN  final value; to register file Data_in
//  rd_out   out  RD_W  latched destination; to register file RD
//  enW      out  1     register write enable = done && (rd_out != 0)
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, counter=0, busy=0, done=0, enW=0, result=0, rd_out=0.
//   Reset mid-operation aborts silently: no done, no enW, partial result discarded.
//  States: IDLE, MUL, DIV, DONE.
//   IDLE/DONE + start: latch funct3, rd_in, operands; counter=0;
//     funct3[2]==0 -> MUL; funct3[2]==1 and special case -> DONE; else -> DIV.
//   IDLE/DONE, no start -> IDLE.  MUL/DIV: counter++ each edge; at counter==XLEN-1 -> DONE.
//   start while busy is ignored (no re-latch, no effect on current op).
//  Latency: accepting edge N; iterative ops raise done after edge N+XLEN (done high for the
//   cycle between edges N+XLEN and N+XLEN+1); special cases raise done after edge N.
//  done, enW high only in DONE. result, rd_out hold their value until the next accepted start.
//  Back-to-back: start asserted during DONE is accepted on that edge.
//  Multiply: operands converted to magnitudes per signedness (MUL/MULH: both signed;
//   MULHSU: A signed, B unsigned; MULHU: both unsigned); XLEN-step shift-add into 2*XLEN
//   product; negate if signs differ. MUL returns low XLEN bits, others high XLEN bits.
//  Divide: restoring, one quotient bit per cycle on magnitudes (DIV/REM signed).
//   Quotient sign = sign(A) xor sign(B); remainder sign = sign(A). Truncating toward zero.
//  Special cases (1-cycle, no iteration):
//   B==0: DIV/DIVU -> all ones; REM/REMU -> A.
//   signed overflow A==0x80000000, B==0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
//  Writes to x0: done still pulses, enW stays 0.
// TESTING
//  1 MUL 7 * 0xFFFFFFFD, rd_in=5 -> busy for 32 cycles; result 0xFFFFFFEB, done 1 cycle
//    after edge N+32, enW=1, rd_out=5.
//  2 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//    MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  3 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  4 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, done 1 cycle after start edge, busy never high;
//    DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
//  5 start re-pulsed at cycle 10 of a DIV with new operands -> ignored, original result;
//    op with rd_in=0 -> done pulses, enW=0.
//  6 reset low at cycle 10 of MUL -> busy/done/enW/result=0 immediately; after release,
//    new DIVU 9/3 -> result 3 after 32 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle handling of divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [RD_W-1:0] rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out,
    output logic            enW
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic            neg_q;
    logic [CW-1:0]   count_q;

    logic            accept, last;
    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_by_zero, overflow, special, neg_start;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
    logic [2*XLEN-1:0] mul_prod, mul_signed;
    logic [XLEN-1:0]   mul_final;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ok;
    logic [XLEN-1:0]   div_hi_n, div_lo_n, div_raw, div_final;

    // Operand decode: signedness, magnitudes and the single-cycle special cases
    always_comb begin
        a_signed    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed    = funct3[2] ? ~funct3[0] : ~funct3[1];
        sign_a      = a_signed & rs1_val[XLEN-1];
        sign_b      = b_signed & rs2_val[XLEN-1];
        mag_a       = sign_a ? -rs1_val : rs1_val;
        mag_b       = sign_b ? -rs2_val : rs2_val;
        neg_start   = (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
        div_by_zero = funct3[2] && (rs2_val == '0);
        overflow    = funct3[2] && !funct3[0]
                      && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        special     = div_by_zero || overflow;
        if (div_by_zero)
            special_res = funct3[1] ? rs1_val : '1;
        else
            special_res = funct3[1] ? '0 : rs1_val;
    end

    // One iteration step; mul uses {hi,lo} as the product with b_q the multiplicand,
    // div uses hi as the partial remainder and lo as dividend shifting into quotient
    always_comb begin
        mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        mul_hi_n   = mul_sum[XLEN:1];
        mul_lo_n   = {mul_sum[0], lo_q[XLEN-1:1]};
        mul_prod   = {mul_hi_n, mul_lo_n};
        mul_signed = neg_q ? -mul_prod : mul_prod;
        mul_final  = (op_q[1:0] == 2'b00) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];

        div_shift  = {hi_q, lo_q[XLEN-1]};
        div_diff   = div_shift - {1'b0, b_q};
        div_ok     = ~div_diff[XLEN];
        div_hi_n   = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_lo_n   = {lo_q[XLEN-2:0], div_ok};
        div_raw    = op_q[1] ? div_hi_n : div_lo_n;
        div_final  = neg_q ? -div_raw : div_raw;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = (count_q == CW'(XLEN-1));
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                done   = (state_q == DONE);
                accept = start;
                if (start)
                    state_d = !funct3[2] ? MUL : (special ? DONE : DIV);
                else
                    state_d = IDLE;
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        enW = done && (rd_out != '0);
    end

    // Datapath: latch on accept, iterate while busy, publish result on the last step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            count_q <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else if (accept) begin
            op_q    <= funct3;
            rd_out  <= rd_in;
            count_q <= '0;
            hi_q    <= '0;
            neg_q   <= neg_start;
            lo_q    <= funct3[2] ? mag_a : mag_b;
            b_q     <= funct3[2] ? mag_b : mag_a;
            if (special) result <= special_res;
        end else if (busy) begin
            count_q <= count_q + CW'(1);
            if (state_q == MUL) begin
                hi_q <= mul_hi_n;
                lo_q <= mul_lo_n;
                if (last) result <= mul_final;
            end else begin
                hi_q <= div_hi_n;
                lo_q <= div_lo_n;
                if (last) result <= div_final;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, write enable and reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_val = '0, rs2_val = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, enW;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_compared = 0;
    int n_mismatched = 0;

    muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out), .enW(enW)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        @(negedge clk);
        funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; optionally re-pulses start mid-op
    task automatic wait_done(input int repulse, output int lat, output logic busy_seen);
        lat = 0;
        busy_seen = 1'b0;
        while (!done && lat < 100) begin
            busy_seen |= busy;
            if (repulse != 0 && lat == repulse) begin
                funct3 = 3'b000; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd9;
                start = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            lat++;
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd,
                                  input logic [31:0] exp, input int exp_lat,
                                  input bit chain, input int repulse);
        int   lat;
        logic busy_seen;
        start_op(f3, a, b, rd);
        wait_done(repulse, lat, busy_seen);
        check_output({tag, "_result"}, result, exp);
        check_output({tag, "_latency"}, lat, exp_lat);
        check_output({tag, "_busy"}, {31'd0, busy_seen}, {31'd0, exp_lat != 0});
        check_output({tag, "_done"}, {31'd0, done}, 32'd1);
        check_output({tag, "_enW"}, {31'd0, enW}, {31'd0, rd != 5'd0});
        check_output({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
        if (!chain) begin
            @(posedge clk);
            #1;
            check_output({tag, "_done_drop"}, {31'd0, done}, 32'd0);
            check_output({tag, "_enW_drop"}, {31'd0, enW}, 32'd0);
            check_output({tag, "_hold"}, result, exp);
        end
    endtask

    initial begin
        #12;
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_done", {31'd0, done}, 32'd0);
        check_output("reset_enW", {31'd0, enW}, 32'd0);
        check_output("reset_result", result, 32'd0);
        check_output("reset_rd", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        apply_stimulus("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 32, 0, 0);
        apply_stimulus("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 32, 0, 0);
        apply_stimulus("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 32, 0, 0);
        apply_stimulus("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 32, 0, 0);
        apply_stimulus("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd1, 32'hFFFFFFFD, 32, 0, 0);
        apply_stimulus("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd2, 32'hFFFFFFFF, 32, 0, 0);
        apply_stimulus("divu",   3'b101, 32'd100,      32'd7,        5'd3, 32'd14,       32, 0, 0);
        apply_stimulus("remu",   3'b111, 32'd100,      32'd7,        5'd4, 32'd2,        32, 0, 0);
        apply_stimulus("div0",   3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 0, 0, 0);
        apply_stimulus("rem0",   3'b110, 32'd5,        32'd0,        5'd11, 32'd5,        0, 0, 0);
        apply_stimulus("divov",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 0, 0, 0);
        apply_stimulus("remov",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        0, 0, 0);
        apply_stimulus("repulse", 3'b101, 32'd100,     32'd7,        5'd3, 32'd14,       32, 0, 10);
        apply_stimulus("x0",     3'b000, 32'd3,        32'd4,        5'd0, 32'd12,       32, 0, 0);
        apply_stimulus("b2b_a",  3'b111, 32'd5,        32'd0,        5'd14, 32'd5,        0, 1, 0);
        apply_stimulus("b2b_b",  3'b000, 32'hFFFFFFFF, 32'd6,        5'd15, 32'hFFFFFFFA, 32, 0, 0);

        // Abort a multiply with reset partway through
        start_op(3'b000, 32'd9, 32'd9, 5'd20);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_done", {31'd0, done}, 32'd0);
        check_output("abort_enW", {31'd0, enW}, 32'd0);
        check_output("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus("post_reset", 3'b101, 32'd9, 32'd3, 5'd21, 32'd3, 32, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
